// File: rtl/uart_boot_loader.sv
// Boot loader: parses MAGIC, 16-bit word count and little-endian 32-bit words from a UART byte stream
// and writes them to instruction memory. Optional trailing XOR checksum when UART_LOADER_CHECKSUM_EN is defined.
module uart_boot_loader #(
  parameter int          ADDR_WIDTH   = 10,
  parameter logic [7:0]  MAGIC        = 8'hA5,
  parameter int          TIMEOUT_CLKS = 2000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_dv,
  input  logic [7:0]            rx_byte,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int          TW        = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
`ifdef UART_LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           count_q, count_d;
  logic [15:0]           idx_q, idx_d;
  logic [1:0]            lane_q, lane_d;
  logic [23:0]           word_q, word_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  take_err, finish, counting;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    idx_d       = idx_q;
    lane_d      = lane_q;
    word_d      = word_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_reset_d = cpu_reset_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = error_q;
    take_err    = 1'b0;
    finish      = 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    counting = (state_q != S_IDLE) && (state_q != S_DONE);
    // An accepted byte always beats an expiring timeout in the same cycle.
    tmo_d = (!counting || rx_dv) ? '0 : tmo_q + TW'(1);

    case (state_q)
      S_IDLE: begin
        if (rx_dv && rx_byte == MAGIC) begin
          state_d     = S_LEN_LO;
          busy_d      = 1'b1;
          cpu_reset_d = 1'b1;
          error_d     = 1'b0;
          count_d     = '0;
          idx_d       = '0;
          lane_d      = '0;
`ifdef UART_LOADER_CHECKSUM_EN
          csum_d      = '0;
`endif
        end
      end
      S_LEN_LO: begin
        if (rx_dv) begin
          count_d[7:0] = rx_byte;
          state_d      = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (rx_dv) begin
          count_d = {rx_byte, count_q[7:0]};
          if ({1'b0, count_d} > MAX_WORDS) begin
            take_err = 1'b1;
          end else if (count_d == 16'd0) begin
`ifdef UART_LOADER_CHECKSUM_EN
            state_d = S_CHECK;
`else
            finish  = 1'b1;
`endif
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (rx_dv) begin
`ifdef UART_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ rx_byte;
`endif
          if (lane_q == 2'd3) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = idx_q[ADDR_WIDTH-1:0];
            mem_wdata_d = {rx_byte, word_q};
            idx_d       = idx_q + 16'd1;
            lane_d      = 2'd0;
            if (idx_q + 16'd1 == count_q) begin
`ifdef UART_LOADER_CHECKSUM_EN
              state_d = S_CHECK;
`else
              finish  = 1'b1;
`endif
            end
          end else begin
            // Shift right so lane 0 ends up in the low byte after three bytes.
            word_d = {rx_byte, word_q[23:8]};
            lane_d = lane_q + 2'd1;
          end
        end
      end
`ifdef UART_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (rx_dv) begin
          if (rx_byte == csum_q) finish   = 1'b1;
          else                   take_err = 1'b1;
        end
      end
`endif
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (counting && !rx_dv && tmo_q == TW'(TIMEOUT_CLKS - 1)) take_err = 1'b1;

    // Failure leaves the core held in reset; only a good load releases it.
    if (take_err) begin
      error_d = 1'b1;
      busy_d  = 1'b0;
      state_d = S_IDLE;
      tmo_d   = '0;
    end else if (finish) begin
      done_d      = 1'b1;
      busy_d      = 1'b0;
      cpu_reset_d = 1'b0;
      state_d     = S_DONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      idx_q       <= '0;
      lane_q      <= '0;
      word_q      <= '0;
      tmo_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_reset_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      lane_q      <= lane_d;
      word_q      <= word_d;
      tmo_q       <= tmo_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
`ifdef UART_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_reset = cpu_reset_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: vector table for a full load, hand-written
// sequences for oversize count, timeout, async reset and checksum handling.
module tb_uart_boot_loader;

  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_reset, busy, done, error;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int done_cnt = 0;

  uart_boot_loader #(.ADDR_WIDTH(10), .MAGIC(8'hA5), .TIMEOUT_CLKS(TMO)) dut (
    .clk(clk), .rst(rst), .rx_dv(rx_dv), .rx_byte(rx_byte),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      we_cnt   <= 0;
      done_cnt <= 0;
    end else begin
      if (mem_we) we_cnt <= we_cnt + 1;
      if (done)   done_cnt <= done_cnt + 1;
    end
  end

  typedef struct {
    logic        dv;
    logic [7:0]  b;
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic        busy;
    logic        cpu;
    logic        done;
    logic        err;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic dv, input logic [7:0] b, input logic we, input logic [9:0] addr,
                     input logic [31:0] wdata, input logic bz, input logic cpu, input logic dn,
                     input logic er);
    vec_t v;
    v.dv = dv; v.b = b; v.we = we; v.addr = addr; v.wdata = wdata;
    v.busy = bz; v.cpu = cpu; v.done = dn; v.err = er;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic dv, input logic [7:0] b);
    rx_dv = dv;
    rx_byte = b;
    @(posedge clk);
    #1;
    rx_dv = 1'b0;
    rx_byte = 8'h00;
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap_we, snap_done;
    logic [7:0] cs;

    // Noise in IDLE, then count=2 frame with DEADBEEF, 00000013.
    add(1, 8'h00, 0, 10'd0, 32'h0,        0, 0, 0, 0);
    add(1, 8'h42, 0, 10'd0, 32'h0,        0, 0, 0, 0);
    add(1, 8'hA5, 0, 10'd0, 32'h0,        1, 1, 0, 0);
    add(1, 8'h02, 0, 10'd0, 32'h0,        1, 1, 0, 0);
    add(1, 8'h00, 0, 10'd0, 32'h0,        1, 1, 0, 0);
    add(1, 8'hEF, 0, 10'd0, 32'h0,        1, 1, 0, 0);
    add(0, 8'h00, 0, 10'd0, 32'h0,        1, 1, 0, 0);
    add(1, 8'hBE, 0, 10'd0, 32'h0,        1, 1, 0, 0);
    add(1, 8'hAD, 0, 10'd0, 32'h0,        1, 1, 0, 0);
    add(1, 8'hDE, 1, 10'd0, 32'hDEADBEEF, 1, 1, 0, 0);
    add(1, 8'h13, 0, 10'd0, 32'hDEADBEEF, 1, 1, 0, 0);
    add(1, 8'h00, 0, 10'd0, 32'hDEADBEEF, 1, 1, 0, 0);
    add(1, 8'h00, 0, 10'd0, 32'hDEADBEEF, 1, 1, 0, 0);
`ifdef UART_LOADER_CHECKSUM_EN
    add(1, 8'h00, 1, 10'd1, 32'h00000013, 1, 1, 0, 0);
    add(1, 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF ^ 8'h13,
                  0, 10'd1, 32'h00000013, 0, 0, 1, 0);
`else
    add(1, 8'h00, 1, 10'd1, 32'h00000013, 0, 0, 1, 0);
`endif
    add(0, 8'h00, 0, 10'd1, 32'h00000013, 0, 0, 0, 0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset mem_we", mem_we, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset mem_wdata", mem_wdata, 0);
    chk("reset cpu_reset", cpu_reset, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset error", error, 0);
    rst = 1'b0;
    idle(2);

    foreach (tbl[i]) begin
      step(tbl[i].dv, tbl[i].b);
      chk($sformatf("vec%0d mem_we", i), mem_we, tbl[i].we);
      chk($sformatf("vec%0d mem_addr", i), mem_addr, tbl[i].addr);
      chk($sformatf("vec%0d mem_wdata", i), mem_wdata, tbl[i].wdata);
      chk($sformatf("vec%0d busy", i), busy, tbl[i].busy);
      chk($sformatf("vec%0d cpu_reset", i), cpu_reset, tbl[i].cpu);
      chk($sformatf("vec%0d done", i), done, tbl[i].done);
      chk($sformatf("vec%0d error", i), error, tbl[i].err);
    end
    chk("load write count", we_cnt, 2);
    chk("load done count", done_cnt, 1);

    // Oversize count 0x0401 > 1024
    snap_we = we_cnt;
    send(8'hA5); send(8'h01); send(8'h04);
    chk("oversize error", error, 1);
    chk("oversize busy", busy, 0);
    chk("oversize cpu_reset", cpu_reset, 1);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    idle(2);
    chk("oversize no write", we_cnt, snap_we);
    chk("oversize still error", error, 1);

    // Zero-length frame
    snap_done = done_cnt;
    send(8'hA5);
    chk("zero magic clears error", error, 0);
    send(8'h00); send(8'h00);
`ifdef UART_LOADER_CHECKSUM_EN
    chk("zero awaits checksum", done, 0);
    send(8'h00);
`endif
    chk("zero done", done, 1);
    chk("zero cpu_reset", cpu_reset, 0);
    idle(1);
    chk("zero done single", done_cnt, snap_done + 1);

    // Timeout: byte on the expiring cycle wins, then a real stall expires
    snap_we = we_cnt;
    send(8'hA5); send(8'h01); send(8'h00); send(8'h11);
    idle(TMO - 1);
    send(8'h22);
    chk("tmo byte wins error", error, 0);
    chk("tmo byte wins busy", busy, 1);
    idle(TMO - 1);
    chk("tmo before expiry", error, 0);
    idle(1);
    chk("tmo error", error, 1);
    chk("tmo busy", busy, 0);
    chk("tmo cpu_reset", cpu_reset, 1);
    chk("tmo no partial write", we_cnt, snap_we);

    // Async reset mid-DATA
    send(8'hA5); send(8'h02); send(8'h00); send(8'h11); send(8'h22);
    #3;
    rst = 1'b1;
    #1;
    chk("rst busy", busy, 0);
    chk("rst cpu_reset", cpu_reset, 0);
    chk("rst error", error, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);
    send(8'hA5); send(8'h01); send(8'h00);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    chk("restart mem_we", mem_we, 1);
    chk("restart mem_addr", mem_addr, 0);
    chk("restart mem_wdata", mem_wdata, 32'h04030201);
`ifdef UART_LOADER_CHECKSUM_EN
    send(8'h01 ^ 8'h02 ^ 8'h03 ^ 8'h04);
`endif
    chk("restart done", done, 1);
    idle(1);

`ifdef UART_LOADER_CHECKSUM_EN
    // Bad checksum, then a good frame
    snap_we = we_cnt;
    snap_done = done_cnt;
    cs = 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF ^ 8'h13;
    send(8'hA5); send(8'h02); send(8'h00);
    send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
    send(8'h13); send(8'h00); send(8'h00); send(8'h00);
    send(cs ^ 8'hFF);
    idle(1);
    chk("badcs writes", we_cnt, snap_we + 2);
    chk("badcs error", error, 1);
    chk("badcs no done", done_cnt, snap_done);
    chk("badcs cpu_reset", cpu_reset, 1);
    send(8'hA5); send(8'h02); send(8'h00);
    send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
    send(8'h13); send(8'h00); send(8'h00); send(8'h00);
    send(cs);
    chk("goodcs done", done, 1);
    chk("goodcs error", error, 0);
    chk("goodcs cpu_reset", cpu_reset, 0);
`else
    cs = 8'h00;
    chk("final idle busy", busy, {7'd0, cs[0]});
`endif
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
